// File: rtl/jump_target_buffer.sv
// jump_target_buffer: set-associative target buffer for unconditional jumps with tree-PLRU and an init/invalidate sweep
//   clk, resetn              clock, asynchronous active-low reset
//   invalidate / init_busy   restart the clearing sweep / sweep in progress
//   lookup_pc/lookup_valid   PREDICT_PORTS combinational lookups -> pred_hit/pred_target
//   update_valid/pc/target   resolved jump from EXE, accepted when update_ready
module jump_target_buffer #(
    parameter int WAYS          = 4,
    parameter int SETS          = 8,
    parameter int TAG_BITS      = 18,
    parameter int INDEX_SHIFT   = 5,
    parameter int PREDICT_PORTS = 2,
    parameter int ADDR_WIDTH    = 32
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                invalidate,
    output logic                                init_busy,
    input  logic [PREDICT_PORTS*ADDR_WIDTH-1:0] lookup_pc,
    input  logic [PREDICT_PORTS-1:0]            lookup_valid,
    output logic [PREDICT_PORTS-1:0]            pred_hit,
    output logic [PREDICT_PORTS*ADDR_WIDTH-1:0] pred_target,
    input  logic                                update_valid,
    input  logic [ADDR_WIDTH-1:0]               update_pc,
    input  logic [ADDR_WIDTH-1:0]               update_target,
    output logic                                update_ready
);
    localparam int LOG_WAYS = $clog2(WAYS);
    localparam int LOG_SETS = $clog2(SETS);
    localparam int NODES    = WAYS - 1;
    localparam int MW       = TAG_BITS + 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                        state, state_d;
    logic [LOG_SETS-1:0]           cnt, cnt_d;
    logic                          plru_clr;
    logic                          running;
    logic [WAYS*MW-1:0]            meta_mem [SETS];
    logic [ADDR_WIDTH-1:0]         tgt_mem [SETS][WAYS];
    logic [SETS-1:0][NODES-1:0]    plru, plru_d;
    logic [LOG_SETS-1:0]           lk_idx [PREDICT_PORTS];
    logic [LOG_WAYS-1:0]           lk_way [PREDICT_PORTS];
    logic [LOG_SETS-1:0]           u_idx;
    logic [TAG_BITS-1:0]           u_tag;
    logic                          u_en, u_hit, u_inv;
    logic [LOG_WAYS-1:0]           u_hit_way, u_inv_way, u_way;
    logic                          unused_pc;

    // Heap-ordered tree: node n has children 2n+1 (low half) and 2n+2 (high half).
    // Each node on the way's path is made to point at the other half.
    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] bits, input logic [LOG_WAYS-1:0] w);
        logic [NODES-1:0]    r;
        logic [LOG_WAYS-1:0] ws;
        logic                b;
        int                  n;
        r  = bits;
        ws = w;
        n  = 0;
        for (int l = 0; l < LOG_WAYS; l++) begin
            b  = ws[LOG_WAYS-1];
            r  = (r & ~(NODES'(1) << n)) | (NODES'(~b) << n);
            ws = ws << 1;
            n  = 2 * n + 1 + int'(b);
        end
        return r;
    endfunction

    function automatic logic [LOG_WAYS-1:0] victim(input logic [NODES-1:0] bits);
        logic [NODES-1:0]    t;
        logic [LOG_WAYS-1:0] w;
        int                  n;
        w = '0;
        n = 0;
        for (int l = 0; l < LOG_WAYS; l++) begin
            t = bits >> n;
            w = (w << 1) | LOG_WAYS'(t[0]);
            n = 2 * n + 1 + int'(t[0]);
        end
        return w;
    endfunction

    assign running      = state == RUN;
    assign init_busy    = ~running;
    assign update_ready = running;
    assign u_en         = running & update_valid;
    assign u_idx        = update_pc[INDEX_SHIFT +: LOG_SETS];
    assign u_tag        = update_pc[2 +: TAG_BITS];
    assign unused_pc    = ^{lookup_pc, update_pc};

    always_comb begin
        state_d  = invalidate ? INIT : (!running && cnt == LOG_SETS'(SETS - 1)) ? RUN : state;
        cnt_d    = invalidate ? '0 : running ? cnt : cnt + 1'b1;
        plru_clr = invalidate;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= INIT;
            cnt   <= '0;
            plru  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            plru  <= plru_clr ? '0 : plru_d;
        end
    end

    // Storage has no reset: the sweep clears the valid bits before RUN is entered.
    always_ff @(posedge clk) begin
        if (!running) begin
            meta_mem[cnt] <= '0;
        end else if (u_en) begin
            if (!u_hit)
                meta_mem[u_idx][u_way*MW +: MW] <= {1'b1, u_tag};
            tgt_mem[u_idx][u_way] <= update_target;
        end
    end

    for (genvar g = 0; g < PREDICT_PORTS; g++) begin : g_port
        logic [LOG_SETS-1:0]   idx;
        logic [TAG_BITS-1:0]   tag;
        logic                  hit;
        logic [LOG_WAYS-1:0]   way;
        logic [ADDR_WIDTH-1:0] tgt;
        assign idx = lookup_pc[g*ADDR_WIDTH + INDEX_SHIFT +: LOG_SETS];
        assign tag = lookup_pc[g*ADDR_WIDTH + 2 +: TAG_BITS];
        always_comb begin
            hit = 1'b0;
            way = '0;
            tgt = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (meta_mem[idx][w*MW +: MW] == {1'b1, tag}) begin
                    hit = 1'b1;
                    way = LOG_WAYS'(w);
                    tgt = tgt_mem[idx][w];
                end
            end
        end
        assign pred_hit[g]                              = running & lookup_valid[g] & hit;
        assign pred_target[g*ADDR_WIDTH +: ADDR_WIDTH]  = pred_hit[g] ? tgt : '0;
        assign lk_idx[g]                                = idx;
        assign lk_way[g]                                = way;
    end

    always_comb begin
        u_hit     = 1'b0;
        u_hit_way = '0;
        u_inv     = 1'b0;
        u_inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (meta_mem[u_idx][w*MW +: MW] == {1'b1, u_tag}) begin
                u_hit     = 1'b1;
                u_hit_way = LOG_WAYS'(w);
            end
        end
        // Scan downwards so the lowest-index invalid way is the one kept.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!meta_mem[u_idx][w*MW + TAG_BITS]) begin
                u_inv     = 1'b1;
                u_inv_way = LOG_WAYS'(w);
            end
        end
        u_way = u_hit ? u_hit_way : u_inv ? u_inv_way : victim(plru[u_idx]);
    end

    // Touches are chained port 0..P-1 then the update, so later touches win per node.
    always_comb begin
        plru_d = plru;
        for (int p = 0; p < PREDICT_PORTS; p++)
            if (pred_hit[p])
                plru_d[lk_idx[p]] = touch(plru_d[lk_idx[p]], lk_way[p]);
        if (u_en)
            plru_d[u_idx] = touch(plru_d[u_idx], u_way);
    end
endmodule

// File: tb/tb_jump_target_buffer.sv
// tb_jump_target_buffer: directed scoreboard bench for jump_target_buffer
module tb_jump_target_buffer;
    logic        clk;
    logic        resetn;
    logic        invalidate;
    logic        init_busy;
    logic [63:0] lookup_pc;
    logic [1:0]  lookup_valid;
    logic [1:0]  pred_hit;
    logic [63:0] pred_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_ready;

    int vectors = 0;
    int miscompares = 0;
    int busy;

    string       exp_name [$];
    int          exp_port [$];
    logic        exp_hit  [$];
    logic [31:0] exp_tgt  [$];

    localparam logic [31:0] A  = 32'h0040_0020, B  = 32'h0040_0120, C  = 32'h0040_0220;
    localparam logic [31:0] D  = 32'h0040_0320, E  = 32'h0040_0420, F  = 32'h0040_0520;
    localparam logic [31:0] G0 = 32'h0040_0040, G1 = 32'h0040_0140, G2 = 32'h0040_0240;
    localparam logic [31:0] G3 = 32'h0040_0340, H  = 32'h0040_0440, S  = 32'h0040_0060;

    jump_target_buffer dut (
        .clk           (clk),
        .resetn        (resetn),
        .invalidate    (invalidate),
        .init_busy     (init_busy),
        .lookup_pc     (lookup_pc),
        .lookup_valid  (lookup_valid),
        .pred_hit      (pred_hit),
        .pred_target   (pred_target),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_target (update_target),
        .update_ready  (update_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    task automatic push(input string nm, input int p, input logic h, input logic [31:0] t);
        exp_name.push_back(nm);
        exp_port.push_back(p);
        exp_hit.push_back(h);
        exp_tgt.push_back(t);
    endtask

    task automatic score();
        while (exp_port.size() > 0) begin
            string       n;
            int          p;
            logic        h;
            logic [31:0] t;
            n = exp_name.pop_front();
            p = exp_port.pop_front();
            h = exp_hit.pop_front();
            t = exp_tgt.pop_front();
            check({n, "_hit"}, 32'(pred_hit[p]), 32'(h));
            check({n, "_tgt"}, pred_target[p*32 +: 32], t);
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic h, input logic [31:0] t, input string nm);
        lookup_pc    = {32'h0, pc};
        lookup_valid = 2'b01;
        push(nm, 0, h, t);
        push({nm, "_p1idle"}, 1, 1'b0, 32'h0);
        #1;
        score();
        @(negedge clk);
        lookup_valid = 2'b00;
    endtask

    task automatic look2(input logic [31:0] pc0, input logic [31:0] t0, input logic [31:0] pc1,
                         input logic [31:0] t1, input string nm);
        lookup_pc    = {pc1, pc0};
        lookup_valid = 2'b11;
        push({nm, "_p0"}, 0, 1'b1, t0);
        push({nm, "_p1"}, 1, 1'b1, t1);
        #1;
        score();
        @(negedge clk);
        lookup_valid = 2'b00;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] t);
        update_pc     = pc;
        update_target = t;
        update_valid  = 1'b1;
        @(negedge clk);
        update_valid  = 1'b0;
    endtask

    initial begin
        resetn        = 1'b0;
        invalidate    = 1'b0;
        update_valid  = 1'b0;
        update_pc     = '0;
        update_target = '0;
        lookup_pc     = {G0, A};
        lookup_valid  = 2'b11;
        #3;
        check("rst_busy", 32'(init_busy), 32'd1);
        check("rst_ready", 32'(update_ready), 32'd0);
        check("rst_hit", 32'(pred_hit), 32'd0);
        check("rst_tgt", pred_target[31:0] | pred_target[63:32], 32'd0);
        lookup_valid = 2'b00;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        busy = 0;
        while (init_busy && busy < 50) begin
            busy++;
            @(negedge clk);
            #1;
        end
        check("init_len", busy, 32'd8);
        check("ready_after_init", 32'(update_ready), 32'd1);
        look(A, 1'b0, 32'h0, "empty_a");
        look(G0, 1'b0, 32'h0, "empty_g0");

        update_pc     = A;
        update_target = 32'h0040_1000;
        update_valid  = 1'b1;
        look(A, 1'b0, 32'h0, "same_cycle");
        update_valid  = 1'b0;
        look(A, 1'b1, 32'h0040_1000, "next_cycle");

        update_target = 32'h0040_2000;
        update_valid  = 1'b1;
        look(A, 1'b1, 32'h0040_1000, "rewrite_same_cycle");
        update_valid  = 1'b0;
        look(A, 1'b1, 32'h0040_2000, "rewrite");

        upd(B, 32'h0050_0b00);
        upd(C, 32'h0050_0c00);
        upd(D, 32'h0050_0d00);
        look(A, 1'b1, 32'h0040_2000, "lru_touch_a");
        look(C, 1'b1, 32'h0050_0c00, "lru_touch_c");
        upd(E, 32'h0050_0e00);
        upd(F, 32'h0050_0f00);
        look(B, 1'b0, 32'h0, "evict_b");
        look(D, 1'b0, 32'h0, "evict_d");
        look(A, 1'b1, 32'h0040_2000, "keep_a");
        look(C, 1'b1, 32'h0050_0c00, "keep_c");
        look(E, 1'b1, 32'h0050_0e00, "new_e");
        look(F, 1'b1, 32'h0050_0f00, "new_f");

        upd(G0, 32'h0060_0000);
        upd(G1, 32'h0060_0100);
        upd(G2, 32'h0060_0200);
        upd(G3, 32'h0060_0300);
        look2(G0, 32'h0060_0000, G3, 32'h0060_0300, "dual");
        upd(H, 32'h0060_0400);
        look(G1, 1'b0, 32'h0, "dual_evict_g1");
        look(G0, 1'b1, 32'h0060_0000, "dual_keep_g0");
        look(G2, 1'b1, 32'h0060_0200, "dual_keep_g2");
        look(G3, 1'b1, 32'h0060_0300, "dual_keep_g3");
        look(H, 1'b1, 32'h0060_0400, "dual_new_h");

        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        #1;
        busy = 0;
        while (init_busy && busy < 50) begin
            busy++;
            if (busy == 1) begin
                lookup_pc    = {32'h0, A};
                lookup_valid = 2'b01;
                push("sweep_lookup", 0, 1'b0, 32'h0);
                push("sweep_lookup_p1", 1, 1'b0, 32'h0);
                score();
                check("sweep_ready", 32'(update_ready), 32'd0);
                update_pc     = S;
                update_target = 32'h0070_0000;
                update_valid  = 1'b1;
            end
            if (busy == 3) begin
                invalidate   = 1'b1;
                update_valid = 1'b1;
            end
            @(negedge clk);
            invalidate   = 1'b0;
            update_valid = 1'b0;
            lookup_valid = 2'b00;
            #1;
        end
        check("inval_len", busy, 32'd11);
        look(A, 1'b0, 32'h0, "post_a");
        look(C, 1'b0, 32'h0, "post_c");
        look(E, 1'b0, 32'h0, "post_e");
        look(G0, 1'b0, 32'h0, "post_g0");
        look(H, 1'b0, 32'h0, "post_h");
        look(S, 1'b0, 32'h0, "post_dropped");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
